// File: rtl/rule_conf_arbiter.sv
// Two-master lock arbiter for the deparser rule-configuration write port.
// Optional idle-lock timeout enabled by defining RULE_ARB_TIMEOUT_EN.
module rule_conf_arbiter #(
    parameter int REQ_NUM        = 2,
    parameter int RULE_NUM       = 32,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [1:0]           i_req_valid,
    output logic [1:0]           o_req_ready,
    input  logic [1:0][31:0]     i_req_addr,
    input  logic [1:0][31:0]     i_req_wdata,
    output logic                 o_rule_wren,
    output logic [31:0]          o_rule_addr,
    output logic [31:0]          o_rule_wdata,
    output logic [1:0]           o_grant,
    output logic [CNT_WIDTH-1:0] o_commit_cnt,
    output logic [CNT_WIDTH-1:0] o_drop_cnt
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t      state;
    logic        rr_ptr;
    logic        owner;
    logic        winner;
    logic        sel;
    logic        acc;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        is_stage;
    logic        is_commit;
    logic        drop;

    // Both valid: round-robin pointer decides; otherwise the lone requester.
    assign winner = (&i_req_valid) ? rr_ptr : i_req_valid[1];
    assign sel    = (state == LOCKED) ? owner : winner;

    always_comb begin
        o_req_ready = 2'b00;
        if (state == LOCKED) begin
            o_req_ready[owner] = 1'b1;
        end else if (|i_req_valid) begin
            o_req_ready[winner] = 1'b1;
        end
    end

    assign acc       = i_req_valid[sel] & o_req_ready[sel];
    assign sel_addr  = i_req_addr[sel];
    assign sel_wdata = i_req_wdata[sel];
    assign is_commit = sel_addr[16] & (sel_addr[10:8] == 3'd0);
    assign is_stage  = sel_addr[16] & (sel_addr[10:8] != 3'd0);
    assign drop      = is_commit & ({26'd0, sel_addr[5:0]} >= RULE_NUM);

`ifdef RULE_ARB_TIMEOUT_EN
    localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [IW-1:0] idle_cnt;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            owner        <= 1'b0;
            o_grant      <= 2'b00;
            o_rule_wren  <= 1'b0;
            o_rule_addr  <= 32'd0;
            o_rule_wdata <= 32'd0;
            o_commit_cnt <= '0;
            o_drop_cnt   <= '0;
`ifdef RULE_ARB_TIMEOUT_EN
            idle_cnt     <= '0;
`endif
        end else begin
            o_rule_wren <= 1'b0;
            if (acc && !drop) begin
                o_rule_wren  <= 1'b1;
                o_rule_addr  <= sel_addr;
                o_rule_wdata <= sel_wdata;
            end
            if (acc && is_commit) begin
                if (drop) begin
                    if (o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + 1'b1;
                end else begin
                    if (o_commit_cnt != '1) o_commit_cnt <= o_commit_cnt + 1'b1;
                end
            end
            unique case (state)
                IDLE: begin
`ifdef RULE_ARB_TIMEOUT_EN
                    idle_cnt <= '0;
`endif
                    if (acc) begin
                        if (is_stage) begin
                            state   <= LOCKED;
                            owner   <= sel;
                            o_grant <= sel ? 2'b10 : 2'b01;
                        end else begin
                            rr_ptr <= ~sel;
                        end
                    end
                end
                LOCKED: begin
                    if (acc && is_commit) begin
                        state   <= IDLE;
                        o_grant <= 2'b00;
                        rr_ptr  <= ~owner;
                    end
`ifdef RULE_ARB_TIMEOUT_EN
                    if (acc) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
                        // Abandoned lock: release without issuing a write.
                        state    <= IDLE;
                        o_grant  <= 2'b00;
                        rr_ptr   <= ~owner;
                        idle_cnt <= '0;
                        if (o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
